// File: rtl/ysyx_24070014_mem_responder_pkg.sv
// Shared definitions for the handshaked memory responder: FSM encodings,
// byte-lane count and the default base address of the mapped RAM window.
package ysyx_24070014_mem_responder_pkg;

  localparam int unsigned NUM_LANES         = 4;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned MAX_LATENCY       = 15;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT     = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

endpackage

// File: rtl/ysyx_24070014_mem_array.sv
// Single-port synchronous word RAM with byte-masked writes and a registered
// read port. Contents are never reset.
module ysyx_24070014_mem_array
  import ysyx_24070014_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned DATA_LEN   = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wen,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_LEN-1:0]   wdata,
  input  logic [NUM_LANES-1:0]  wmask,
  output logic [DATA_LEN-1:0]   rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_LEN-1:0] mem [DEPTH];

  // rdata only updates on reads, so it holds the word until the next read
  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (wmask[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ysyx_24070014_mem_responder.sv
// Handshaked single-outstanding memory target with a fixed response latency,
// range checking and byte-masked writes into a word RAM.
module ysyx_24070014_mem_responder
  import ysyx_24070014_mem_responder_pkg::*;
#(
  parameter int unsigned          ADDR_LEN   = 32,
  parameter int unsigned          DATA_LEN   = 32,
  parameter logic [ADDR_LEN-1:0]  BASE_ADDR  = ADDR_LEN'(DEFAULT_BASE_ADDR),
  parameter int unsigned          DEPTH_LOG2 = 12,
  parameter int unsigned          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_LEN-1:0]   req_addr,
  input  logic [DATA_LEN-1:0]   req_wdata,
  input  logic [NUM_LANES-1:0]  req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_LEN-1:0]   resp_rdata,
  output logic                  resp_err
);

  if (LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("LATENCY must be in 0..15");
  end
  if (DATA_LEN != 32) begin : g_bad_data_len
    $error("DATA_LEN must be 32");
  end
  if (DEPTH_LOG2 + 2 > ADDR_LEN) begin : g_bad_depth
    $error("DEPTH_LOG2 too large for ADDR_LEN");
  end

  localparam logic [CNT_W-1:0] LAT_INIT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic                  pend_err;
  logic                  pend_read;
  logic [ADDR_LEN-1:0]   offset;
  logic                  in_range;
  logic                  accept;
  logic [DATA_LEN-1:0]   ram_rdata;

  // Window check: below BASE_ADDR or past the last word is an error
  assign offset   = req_addr - BASE_ADDR;
  assign in_range = (req_addr >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == '0);
  assign accept   = (state == ST_IDLE) && req_valid;

  ysyx_24070014_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_LEN   (DATA_LEN)
  ) u_mem (
    .clk   (clk),
    .en    (accept && in_range),
    .wen   (req_wen),
    .addr  (offset[DEPTH_LOG2+1:2]),
    .wdata (req_wdata),
    .wmask (req_wmask),
    .rdata (ram_rdata)
  );

  // The first RESP cycle loads the response registers from the RAM read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RST_HOLD;
      cnt        <= '0;
      pend_err   <= 1'b0;
      pend_read  <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_RST_HOLD: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        ST_IDLE: begin
          if (req_valid) begin
            pend_err  <= ~in_range;
            pend_read <= ~req_wen & in_range;
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= LAT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_err   <= pend_err;
            resp_rdata <= pend_read ? ram_rdata : '0;
          end else if (resp_ready) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RST_HOLD;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24070014_mem_responder.sv
// Directed bench for the memory responder: one LATENCY=2 instance and one
// LATENCY=0 instance sharing stimulus, selected by sel.
module tb_ysyx_24070014_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wmask = 4'h0;
  logic        resp_ready = 1'b0;

  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic        z_req_ready, z_resp_valid, z_resp_err;
  logic [31:0] z_resp_rdata;

  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign req_ready  = sel ? z_req_ready  : a_req_ready;
  assign resp_valid = sel ? z_resp_valid : a_resp_valid;
  assign resp_rdata = sel ? z_resp_rdata : a_resp_rdata;
  assign resp_err   = sel ? z_resp_err   : a_resp_err;

  ysyx_24070014_mem_responder #(.LATENCY(2)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid & ~sel),
    .req_ready  (a_req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (a_resp_valid),
    .resp_ready (resp_ready & ~sel),
    .resp_rdata (a_resp_rdata),
    .resp_err   (a_resp_err)
  );

  ysyx_24070014_mem_responder #(.LATENCY(0)) dut_z (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid & sel),
    .req_ready  (z_req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (z_resp_valid),
    .resp_ready (resp_ready & sel),
    .resp_rdata (z_resp_rdata),
    .resp_err   (z_resp_err)
  );

  // One full transaction; lat = edges from acceptance until resp_valid is seen
  task automatic xact(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, output logic [31:0] rdata,
                      output logic err, output int lat);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = mask;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL resp_timeout: resp_valid=%b required 1", resp_valid);
    end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, resp_rdata} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h required all 0",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_hold_ready: req_ready=%b required 0", req_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_ready: req_ready=%b required 1", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (resp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_no_resp: resp_valid=%b required 0", resp_valid);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    n_cmp++;
    if (lat !== 3 || rd !== 32'h0 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL write_resp: lat=%0d rdata=%h err=%b required 3/00000000/0", lat, rd, er);
    end
    xact(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (lat !== 3 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      n_bad++;
      $display("FAIL read_back: lat=%0d rdata=%h err=%b required 3/deadbeef/0", lat, rd, er);
    end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er, lat);
    xact(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    xact(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h11BB_33DD || er !== 1'b0) begin
      n_bad++;
      $display("FAIL byte_mask: rdata=%h err=%b required 11bb33dd/0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          w;
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h8000_0010;
    @(posedge clk); #1;
    // a competing write stays asserted while the read is outstanding
    req_wen   = 1'b1;
    req_wdata = 32'h0;
    req_wmask = 4'hF;
    w = 0;
    while (!resp_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0 ||
          req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: vld=%b rdata=%h err=%b rdy=%b required 1/deadbeef/0/0",
                 i, resp_valid, resp_rdata, resp_err, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: vld=%b rdata=%h rdy=%b required 0/00000000/1",
               resp_valid, resp_rdata, req_ready);
    end
    xact(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL bp_no_second_accept: rdata=%h required deadbeef", rd);
    end
  endtask

  task automatic test_range_error();
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    xact(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL err_below: err=%b rdata=%h required 1/00000000", er, rd);
    end
    xact(1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, rd, er, lat);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL err_above: err=%b rdata=%h required 1/00000000", er, rd);
    end
    xact(1'b0, 32'h8000_3FFC, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (er !== 1'b0) begin
      n_bad++;
      $display("FAIL last_word_in_range: err=%b required 0", er);
    end
    xact(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
      n_bad++;
      $display("FAIL err_write_suppressed: rdata=%h err=%b required cafef00d/0", rd, er);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat;
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0030;
    req_wdata = 32'h5A5A_5A5A;
    req_wmask = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_clear: vld=%b rdy=%b required 0/0", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (resp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_reset_dropped[%0d]: resp_valid=%b required 0", i, resp_valid);
      end
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_idle: req_ready=%b required 1", req_ready);
    end
    xact(1'b0, 32'h8000_0030, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h5A5A_5A5A || er !== 1'b0 || lat !== 3) begin
      n_bad++;
      $display("FAIL mid_reset_committed: rdata=%h err=%b lat=%0d required 5a5a5a5a/0/3",
               rd, er, lat);
    end
  endtask

  task automatic test_latency0();
    logic [31:0] rd;
    logic        er;
    int          lat;
    sel = 1'b1;
    #1;
    xact(1'b1, 32'h8000_0040, 32'h0BAD_CAFE, 4'hF, rd, er, lat);
    n_cmp++;
    if (lat !== 1 || rd !== 32'h0 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL lat0_write: lat=%0d rdata=%h err=%b required 1/00000000/0", lat, rd, er);
    end
    xact(1'b0, 32'h8000_0040, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (lat !== 1 || rd !== 32'h0BAD_CAFE || er !== 1'b0) begin
      n_bad++;
      $display("FAIL lat0_read: lat=%0d rdata=%h err=%b required 1/0badcafe/0", lat, rd, er);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_backpressure();
    test_range_error();
    test_reset_mid();
    test_latency0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
